// File: rtl/alu_shift_sequencer.sv
// Bit-serial SLL/SRL/SRA engine: shifts the latched operand one position per clock
// and pulses done when the shift count expires.
//   state | meaning
//   IDLE  | waiting for a shift request (reset state)
//   SHIFT | one-bit shift per cycle, cnt counting down
//   DONE  | result valid, done pulse; may accept the next request
module alu_shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [WIDTH-1:0] in1,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work, work_shifted, result_nxt;
    logic [SHW-1:0]   cnt;
    logic             op_left, op_arith;
    logic             accept, load_result, last_shift;

    assign accept = start && !flush && (state == IDLE || state == DONE)
                    && (funct3 == 3'b001 || funct3 == 3'b101);

    assign last_shift = (state == SHIFT) && (cnt == SHW'(1));

    assign work_shifted = op_left ? {work[WIDTH-2:0], 1'b0}
                                  : {(op_arith & work[WIDTH-1]), work[WIDTH-1:1]};

    always_comb begin
        state_nxt   = state;
        load_result = 1'b0;
        result_nxt  = work_shifted;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_nxt   = DONE;
                    load_result = 1'b1;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nxt = (shamt == '0) ? DONE : SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A zero-length shift completes straight from the operand.
        if (accept && shamt == '0) begin
            load_result = 1'b1;
            result_nxt  = in1;
        end
        if (flush) begin
            state_nxt   = IDLE;
            load_result = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            work     <= '0;
            cnt      <= '0;
            op_left  <= 1'b0;
            op_arith <= 1'b0;
            result   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work     <= in1;
                cnt      <= shamt;
                op_left  <= (funct3 == 3'b001);
                op_arith <= (funct3 == 3'b101) && funct7_5;
            end else if (state == SHIFT && !flush) begin
                work <= work_shifted;
                cnt  <= cnt - SHW'(1);
            end
            if (load_result) begin
                result <= result_nxt;
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: doc/alu_shift_sequencer.md
# alu_shift_sequencer

Multi-cycle shift controller for the RV32I ALU. It executes SLL/SRL/SRA (and the immediate forms) one bit per clock instead of through a single-cycle barrel shifter, which saves fabric on the GateMate E1. The core's EXECUTE state hands it operand, shift amount and funct bits, then stalls until `done` pulses. The result then goes to register write-back.

## Interface
- `WIDTH`, default 32: datapath width in bits.
- `SHW`, default 5: shift-amount width; must equal log2(`WIDTH`).
- `clk`  in  1: system clock (post-gearbox); all state updates on its rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled on rising `clk`.
- `flush`  in  1: synchronous abort of the operation in progress.
- `funct3`  in  3: instruction funct3; 3'b001 means shift left, 3'b101 means shift right.
- `funct7_5`  in  1: instruction bit 30; 1 selects arithmetic right shift.
- `in1`  in  WIDTH: operand (rs1 value).
- `shamt`  in  SHW: shift amount (rs2[4:0] or instr[24:20]; the core selects which).
- `busy`  out  1: high while shifting.
- `done`  out  1: one-cycle pulse; `result` is valid from this cycle.
- `result`  out  WIDTH: shifted value; held until the next accepted request completes.

## Operation
- States:
  - IDLE: reset state.
  - SHIFT: shifting in progress.
  - DONE: one-cycle completion state.
- Request acceptance:
  - A request is accepted when `start`=1, `flush`=0, state is IDLE or DONE, and `funct3` is 001 or 101.
  - `start` while in SHIFT is ignored, with no queuing.
  - `start` with any other `funct3` is ignored: state stays/returns IDLE and no `done` is produced.
- On acceptance, the following are latched:
  - `in1` into the working register.
  - The operation: SLL if `funct3`=001; SRA if 101 and `funct7_5`=1; SRL if 101 and `funct7_5`=0. `funct7_5` is ignored for SLL.
  - `shamt` into down-counter `cnt`.
  - If `shamt`=0, the next state is DONE. Otherwise the next state is SHIFT.
- Each SHIFT cycle:
  - The working register shifts by exactly 1. SLL fills the LSB with 0, SRL fills the MSB with 0, SRA replicates the MSB.
  - `cnt` decrements.
  - When `cnt`=1 on this edge, the next state is DONE.
- DONE:
  - `done`=1 and `result` = working register.
  - The next state is IDLE, unless a new request is accepted in the same cycle.
- `result` is registered and changes only on entry to DONE.
- `flush`=1 in any state:
  - The next state is IDLE and no `done` is produced.
  - `result` keeps its previous value.
  - `flush` has priority over a simultaneous `start`.
- Inputs are sampled only at acceptance. Changing `in1`/`shamt`/`funct*` during SHIFT has no effect.

## Timing
- Reset (async assert on `resetn`=0): state=IDLE, `busy`=0, `done`=0, `result`=0, `cnt`=0. Release is synchronous to `clk`.
- `resetn` asserted mid-operation aborts immediately: outputs go to reset values with no `done`.
- Latency: with the request accepted in cycle c0, `done` is high in cycle c(`shamt`+1).
  - `shamt`=0: `done` in c1.
  - `shamt`=31: `done` in c32.
- `busy`=1 in cycles c1..c(`shamt`), exactly `shamt` cycles, and is never high together with `done`.
- Back-to-back requests: a request accepted in a DONE cycle starts immediately, so there is no idle bubble. Throughput is one operation per `shamt`+1 cycles.
- `done` is always a single-cycle pulse; two consecutive `done` cycles occur only for back-to-back `shamt`=0 requests.

## Test plan
- Shift left: SLL, `in1`=0x00000001, `shamt`=31 -> `busy` high for 31 cycles; `done` in c32 with `result`=0x80000000.
- Arithmetic and logical right:
  - SRA (`funct7_5`=1), `in1`=0x80000000, `shamt`=5 -> `done` in c6, `result`=0xFC000000.
  - SRL, same operands -> `result`=0x04000000.
  - SRL, `in1`=0x80000000, `shamt`=26 -> `result`=0x00000020.
- Zero shift and back-to-back:
  - SLL, `in1`=0xDEADBEEF, `shamt`=0 -> `done` in c1, `result`=0xDEADBEEF, `busy` never high.
  - A second request in that DONE cycle (SRL by 4) -> `done` in c6, `result`=0x0DEADBEE.
- Ignored requests:
  - `start` pulses during SHIFT, each with different operands -> no effect on `result` or timing.
  - `start` with `funct3`=000 -> no `busy`, no `done`.
- Abort by `flush`: SLL by 20, `flush` asserted in c7 -> IDLE in c8, no `done`, `result` unchanged. `flush`+`start` in the same cycle -> request dropped.
- Abort by reset: SRA by 31, `resetn` pulled low in c10 -> `busy`/`done`/`result` = 0 immediately. After release, a new SLL by 1 of 0x3 gives 0x6 in c2.
